// File: rtl/instr_fetch_unit.sv
// PC register and instruction fetch stage.
// Fetches one word per instruction over req/ack and resolves beq/bne.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CNT_WIDTH      = 5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        advance_i,
  input  logic        branch_eq_i,
  input  logic        branch_ne_i,
  input  logic        zero_i,
  input  logic [31:0] branch_offset_i,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ERR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_nx;
  logic [31:0]          pc;
  logic [31:0]          pc_nx;
  logic [31:0]          instr;
  logic [31:0]          instr_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic                 take;
  logic [31:0]          next_pc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      instr <= instr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    cnt_nx   = cnt;
    take     = (branch_eq_i & zero_i) |
               (branch_ne_i & ~zero_i);
    next_pc  = pc + 32'd4 +
               (take ? (branch_offset_i << 2) : 32'd0);
    case (state)
      IDLE: begin
        state_nx = REQ;
        cnt_nx   = '0;
      end
      REQ: begin
        // an ack on the last allowed cycle still wins over the timeout
        if (imem_ack_i) begin
          instr_nx = imem_rdata_i;
          cnt_nx   = '0;
          state_nx = HOLD;
        end else if (cnt == CNT_LAST) begin
          state_nx = ERR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (advance_i) begin
          pc_nx    = next_pc;
          cnt_nx   = '0;
          state_nx = REQ;
        end
      end
      ERR: begin
        state_nx = ERR;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign imem_req_o    = (state == REQ);
  assign imem_addr_o   = pc;
  assign instr_o       = instr;
  assign instr_valid_o = (state == HOLD);
  assign pc_o          = pc;
  assign pc_plus4_o    = pc + 32'd4;
  assign fetch_err_o   = (state == ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit.
// A transaction-level PC model predicts fetch addresses and data.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        advance_i;
  logic        branch_eq_i;
  logic        branch_ne_i;
  logic        zero_i;
  logic [31:0] branch_offset_i;
  logic        fetch_err_o;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (5)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .advance_i      (advance_i),
    .branch_eq_i    (branch_eq_i),
    .branch_ne_i    (branch_ne_i),
    .zero_i         (zero_i),
    .branch_offset_i(branch_offset_i),
    .fetch_err_o    (fetch_err_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rnd_side();
    advance_i       = 1'($urandom_range(0, 1));
    branch_eq_i     = 1'($urandom_range(0, 1));
    branch_ne_i     = 1'($urandom_range(0, 1));
    zero_i          = 1'($urandom_range(0, 1));
    branch_offset_i = $urandom;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_err", 32'(fetch_err_o), 0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_instr", instr_o, 0);
    @(posedge clk);
    #1;
    imem_ack_i = 1'b0;
    advance_i  = 1'b0;
    @(posedge clk);
    #1;
    rst_n_i   = 1'b1;
    exp_pc    = RST_PC;
    exp_instr = '0;
    @(negedge clk);
    chk("idle_req", 32'(imem_req_o), 0);
    chk("idle_pc", pc_o, RST_PC);
    step();
    chk("restart_req", 32'(imem_req_o), 1);
  endtask

  task automatic await_req();
    int i = 0;
    while (!imem_req_o && i < 4) begin
      step();
      i++;
    end
    chk("req_seen", 32'(imem_req_o), 1);
  endtask

  task automatic fetch(input int lat, input logic [31:0] data);
    await_req();
    chk("addr", imem_addr_o, exp_pc);
    chk("pc", pc_o, exp_pc);
    chk("pc4", pc_plus4_o, exp_pc + 32'd4);
    for (int k = 0; k < lat; k++) begin
      rnd_side();
      step();
      chk("req_hold", 32'(imem_req_o), 1);
      chk("addr_hold", imem_addr_o, exp_pc);
      chk("no_err", 32'(fetch_err_o), 0);
    end
    advance_i    = 1'b0;
    imem_ack_i   = 1'b1;
    imem_rdata_i = data;
    step();
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    exp_instr    = data;
    chk("valid", 32'(instr_valid_o), 1);
    chk("instr", instr_o, exp_instr);
    chk("req_drop", 32'(imem_req_o), 0);
    chk("hold_pc", pc_o, exp_pc);
  endtask

  task automatic retire(input int hold, input logic beq,
                        input logic bne, input logic zero,
                        input logic [31:0] off);
    for (int k = 0; k < hold; k++) begin
      advance_i    = 1'b0;
      imem_ack_i   = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      step();
      chk("hold_valid", 32'(instr_valid_o), 1);
      chk("hold_instr", instr_o, exp_instr);
      chk("hold_pc2", pc_o, exp_pc);
    end
    imem_ack_i      = 1'b0;
    advance_i       = 1'b1;
    branch_eq_i     = beq;
    branch_ne_i     = bne;
    zero_i          = zero;
    branch_offset_i = off;
    step();
    advance_i       = 1'b0;
    branch_eq_i     = 1'($urandom_range(0, 1));
    branch_ne_i     = 1'($urandom_range(0, 1));
    zero_i          = 1'($urandom_range(0, 1));
    branch_offset_i = $urandom;
    if ((beq && zero) || (bne && !zero))
      exp_pc = exp_pc + 32'd4 + off * 32'd4;
    else
      exp_pc = exp_pc + 32'd4;
    chk("retire_valid", 32'(instr_valid_o), 0);
  endtask

  task automatic timeout_test();
    logic [31:0] frozen;
    await_req();
    chk("tmo_addr", imem_addr_o, exp_pc);
    frozen = exp_pc;
    for (int k = 1; k < TMO; k++) begin
      rnd_side();
      step();
      chk("tmo_req", 32'(imem_req_o), 1);
      chk("tmo_noerr", 32'(fetch_err_o), 0);
    end
    advance_i = 1'b0;
    step();
    chk("tmo_err", 32'(fetch_err_o), 1);
    chk("tmo_req_drop", 32'(imem_req_o), 0);
    chk("tmo_valid", 32'(instr_valid_o), 0);
    chk("tmo_pc", pc_o, frozen);
    for (int k = 0; k < 4; k++) begin
      rnd_side();
      imem_ack_i = 1'($urandom_range(0, 1));
      step();
      chk("err_sticky", 32'(fetch_err_o), 1);
      chk("err_pc", pc_o, frozen);
      chk("err_noreq", 32'(imem_req_o), 0);
    end
    imem_ack_i = 1'b0;
    advance_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    rst_n_i         = 1'b1;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = '0;
    advance_i       = 1'b0;
    branch_eq_i     = 1'b0;
    branch_ne_i     = 1'b0;
    zero_i          = 1'b0;
    branch_offset_i = '0;
    exp_pc          = RST_PC;
    exp_instr       = '0;
    #3;
    do_reset();

    for (int i = 0; i < 4; i++) begin
      fetch(0, $urandom);
      retire(0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    end
    fetch(0, $urandom);
    chk("dir_0x10", imem_addr_o, 32'h0040_0010);
    retire(1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    fetch(1, $urandom);
    chk("dir_beq_t", imem_addr_o, 32'h0040_000C);
    retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(0, $urandom);
    retire(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    fetch(2, $urandom);
    chk("dir_beq_nt", imem_addr_o, 32'h0040_0014);
    retire(0, 1'b0, 1'b1, 1'b0, 32'h2);
    fetch(0, $urandom);
    chk("dir_0x20", imem_addr_o, 32'h0040_0020);
    retire(0, 1'b0, 1'b1, 1'b0, 32'h3);
    fetch(0, $urandom);
    chk("dir_bne_t", imem_addr_o, 32'h0040_0030);
    retire(0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFB);
    fetch(0, $urandom);
    retire(0, 1'b0, 1'b1, 1'b1, 32'h3);
    fetch(0, $urandom);
    chk("dir_bne_nt", imem_addr_o, 32'h0040_0024);
    retire(0, 1'b1, 1'b1, 1'b1, 32'h1);
    fetch(0, $urandom);
    chk("dir_both", imem_addr_o, 32'h0040_002C);
    retire(0, 1'b1, 1'b1, 1'b0, 32'h1);

    for (int i = 0; i < 40; i++) begin
      fetch(int'($urandom_range(0, TMO - 1)), $urandom);
      r = $urandom;
      retire(int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             {{16{r[15]}}, r[15:0]});
    end

    fetch(TMO - 1, $urandom);
    chk("late_ack_noerr", 32'(fetch_err_o), 0);
    retire(0, 1'b1, 1'b0, 1'b1,
           (32'hFFFF_FFFC - exp_pc - 32'd4) >> 2);
    fetch(1, $urandom);
    chk("top_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("top_pc4", pc_plus4_o, 32'h0);
    retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(0, $urandom);
    chk("wrap_addr", imem_addr_o, 32'h0);
    retire(0, 1'b0, 1'b0, 1'b0, 32'h0);

    timeout_test();
    do_reset();

    fetch(0, $urandom);
    retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
    await_req();
    imem_ack_i   = 1'b1;
    imem_rdata_i = $urandom;
    #2;
    do_reset();
    fetch(0, $urandom);
    chk("post_rst_addr", imem_addr_o, RST_PC);
    retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(3, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the single-cycle MIPS core, directly upstream of the main control decoder.
- Holds the PC and fetches one 32-bit word per instruction over a req/ack instruction-memory port.
- Presents the held instruction; its opcode field [31:26] feeds the control decoder.
- Computes the next PC from the decoder's branch_eq/branch_ne flags and the ALU zero flag, and flags fetch timeouts.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (word aligned).
- TIMEOUT_CYCLES, 16, max cycles a request may wait for ack before a fault (must be >= 1).
- CNT_WIDTH, 5, width of the timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clk_i  in  1  system clock, all state updates on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  32  fetch byte address (= pc_o while requesting)
- imem_ack_i  in  1  memory returns imem_rdata_i valid this cycle
- imem_rdata_i  in  32  fetched instruction word
- instr_o  out  32  held instruction; [31:26] drives the control decoder opcode
- instr_valid_o  out  1  instr_o valid and being executed
- pc_o  out  32  address of instr_o
- pc_plus4_o  out  32  pc_o + 4
- advance_i  in  1  datapath retires current instruction this cycle
- branch_eq_i  in  1  beq flag from control decoder
- branch_ne_i  in  1  bne flag from control decoder
- zero_i  in  1  ALU zero flag
- branch_offset_i  in  32  sign-extended 16-bit immediate
- fetch_err_o  out  1  sticky timeout fault

Behaviour:
- Reset (async assert, sync-effective deassert on next edge): state=IDLE, pc_o=RESET_PC, instr_o=0, instr_valid_o=0, imem_req_o=0, fetch_err_o=0, timeout counter=0. A reset asserted mid-request drops imem_req_o immediately. A late ack is ignored.
- States: IDLE, REQ, HOLD, ERR.
- IDLE:
  - Outputs inactive.
  - Next cycle goes to REQ unconditionally, giving 1 idle cycle after reset.
- REQ:
  - imem_req_o=1, imem_addr_o=pc_o, both stable until ack.
  - On imem_ack_i: instr_o<=imem_rdata_i, counter<=0, go to HOLD.
  - Otherwise counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack, go to ERR.
  - An ack arriving on that same cycle wins: go to HOLD, no error.
  - Minimum latency is ack in the first REQ cycle, giving instr_valid_o 1 cycle later.
- HOLD:
  - instr_valid_o=1, imem_req_o=0, instr_o and pc_o stable.
  - On advance_i: pc_o<=next_pc, instr_valid_o<=0 in the same edge, go to REQ.
  - Without advance_i it stays in HOLD indefinitely.
- ERR:
  - fetch_err_o=1, imem_req_o=0, instr_valid_o=0, pc_o frozen at the faulting address.
  - Left only by reset.
- next_pc:
  - take = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i).
  - take=1: next_pc = pc_o + 4 + (branch_offset_i << 2), 32-bit modulo, wrap-around allowed.
  - take=0: next_pc = pc_o + 4.
  - If branch_eq_i and branch_ne_i are both 1, take=1 regardless of zero_i.
- Branch inputs and zero_i are sampled only in the cycle advance_i=1 in HOLD. They are ignored elsewhere.
- advance_i is ignored outside HOLD.
- imem_ack_i is ignored outside REQ.
- pc_plus4_o is combinational pc_o+4 and wraps at 32'hFFFF_FFFC.
- pc_o[1:0] is always 0. Offsets are word-scaled, so misalignment cannot arise.

Test Plan:
- Reset, zero-wait memory (ack in first REQ cycle), advance_i held 1 with no branches -> imem_addr_o sequence 0x00400000, 0x00400004, 0x00400008; instr_valid_o high 1 cycle after each ack.
- HOLD at pc=0x00400010, branch_eq_i=1, zero_i=1, offset=0xFFFFFFFE, advance -> next request address 0x0040000C. Repeat with zero_i=0 -> 0x00400014.
- branch_ne_i=1, zero_i=0, offset=0x00000003 at pc=0x00400020 -> next address 0x00400030. With zero_i=1 -> 0x00400024.
- Memory never acks -> fetch_err_o rises exactly TIMEOUT_CYCLES (16) cycles after imem_req_o first asserts, req drops, pc_o frozen. Ack on cycle 16 instead -> no error, HOLD entered.
- Assert rst_n_i low mid-REQ with ack pending -> imem_req_o falls combinationally; after release pc_o=0x00400000, fetch restarts after 1 IDLE cycle.
- advance_i pulsed during REQ and ERR and ack pulsed during HOLD -> no PC or instr_o change. pc=0xFFFFFFFC, no branch -> next address 0x00000000.
